// File: rtl/hs_tx_endpoint.sv
// Transmit side of a four-phase req/ack CDC link: buffers producer words, launches them one at a time.
// Launch one edge after a word is buffered; in_ready drops when the FIFO is full or while in reset.
module hs_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
endmodule

module hs_tx_endpoint #(
    parameter int BUS_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk_tx,
    input  logic                 rst_tx,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] xfer_data,
    output logic                 xfer_req,
    input  logic                 xfer_ack,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] sent_count,
    output logic                 timeout_err,
    input  logic                 clr_err
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   launch;
    logic                   done;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [BUS_WIDTH-1:0]   fifo_head;
    logic [TW-1:0]          tmo_cnt;
    logic [TW-1:0]          tmo_next;
    logic                   tmo_hit;

    assign in_ready = !fifo_full && !rst_tx;

    hs_tx_fifo #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_tx),
        .rst       (rst_tx),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (launch),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_tx or posedge rst_tx) begin
        if (rst_tx) ack_sync <= '0;
        else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
    end
    assign ack_s = ack_sync[SYNC_STAGES-1];

    // A stale ack left high by the receiver blocks a new launch until it drops.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && !ack_s) begin
                    launch     = 1'b1;
                    state_next = REQ_HI;
                end
            end
            REQ_HI: if (ack_s) state_next = REQ_LO;
            REQ_LO: begin
                if (!ack_s) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tmo_next = tmo_cnt;
        if (state_next != state)                          tmo_next = '0;
        else if (state != IDLE && tmo_cnt != TMO_MAX)     tmo_next = tmo_cnt + 1'b1;
    end
    // Saturated counter keeps re-asserting the flag for as long as the phase stalls.
    assign tmo_hit = (TIMEOUT != 0) && (state != IDLE) && (state_next == state)
                     && (tmo_next == TMO_MAX);

    always_ff @(posedge clk_tx or posedge rst_tx) begin
        if (rst_tx) begin
            state       <= IDLE;
            xfer_req    <= 1'b0;
            xfer_data   <= '0;
            sent_count  <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_next;
            xfer_req <= (state_next == REQ_HI);
            tmo_cnt  <= tmo_next;
            if (launch) xfer_data  <= fifo_head;
            if (done)   sent_count <= sent_count + 1'b1;
            if (tmo_hit)      timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
        end
    end

    assign busy = (state != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_hs_tx_endpoint.sv
// Directed and randomized checks of hs_tx_endpoint against a queue-based four-phase receiver model.
module tb_hs_tx_endpoint;
    localparam int BW   = 8;
    localparam int SYNC = 2;
    localparam int TMO  = 8;
    localparam int CW   = 4;

    logic          clk_tx = 1'b0;
    logic          rst_tx = 1'b1;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] xfer_data;
    logic          xfer_req;
    logic          xfer_ack;
    logic          busy;
    logic [CW-1:0] sent_count;
    logic          timeout_err;
    logic          clr_err = 1'b0;

    logic man_ack = 1'b0;
    logic rx_ack  = 1'b0;
    logic rx_auto = 1'b0;
    assign xfer_ack = rx_auto ? rx_ack : man_ack;

    int checks = 0;
    int errors = 0;
    int n;
    int acc;
    int pushed;
    int total_sent = 0;
    int rx_wait = 0;
    int rx_delay = 2;
    logic [BW-1:0] rx_words [$];
    logic [BW-1:0] exp_q [$];

    hs_tx_endpoint #(
        .BUS_WIDTH   (BW),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_tx      (clk_tx),
        .rst_tx      (rst_tx),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .xfer_data   (xfer_data),
        .xfer_req    (xfer_req),
        .xfer_ack    (xfer_ack),
        .busy        (busy),
        .sent_count  (sent_count),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk_tx = ~clk_tx;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Receiver: mirrors req onto ack after a random delay, recording the word it sees.
    initial begin
        forever begin
            @(posedge clk_tx);
            #1;
            if (!rx_auto) begin
                rx_ack  = 1'b0;
                rx_wait = 0;
            end else if (xfer_req != rx_ack) begin
                if (rx_wait >= rx_delay) begin
                    if (xfer_req) rx_words.push_back(xfer_data);
                    rx_ack   = xfer_req;
                    rx_wait  = 0;
                    rx_delay = int'($urandom_range(0, 4));
                end else begin
                    rx_wait++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic do_reset();
        rx_auto  = 1'b0;
        in_valid = 1'b0;
        clr_err  = 1'b0;
        rst_tx   = 1'b1;
        step();
        step();
        rst_tx = 1'b0;
        rx_words.delete();
        total_sent = 0;
        step();
    endtask

    task automatic wait_req(input logic val, output int cnt);
        cnt = 0;
        while (xfer_req !== val && cnt < 60) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait_sent(input int val, output int cnt);
        cnt = 0;
        while (int'(sent_count) != val && cnt < 60) begin
            step();
            cnt++;
        end
    endtask

    task automatic run_random(input int nwords);
        int cyc;
        exp_q.delete();
        rx_words.delete();
        pushed = 0;
        cyc    = 0;
        rx_auto = 1'b1;
        while (!(pushed == nwords && rx_words.size() == nwords && !busy) && cyc < 8000) begin
            if (pushed < nwords) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = BW'($urandom);
                if (in_valid && in_ready) begin
                    exp_q.push_back(in_data);
                    pushed++;
                end
            end else begin
                in_valid = 1'b0;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        total_sent += nwords;
        check("rand_in_time", 32'(cyc < 8000), 1);
        check("rand_word_count", rx_words.size(), nwords);
        for (int i = 0; i < rx_words.size() && i < exp_q.size(); i++)
            check("rand_word", rx_words[i], exp_q[i]);
        check("rand_sent_count", sent_count, total_sent % (1 << CW));
    endtask

    initial begin
        // Reset values
        rst_tx = 1'b1;
        repeat (3) @(posedge clk_tx);
        #1;
        check("rst_req", xfer_req, 0);
        check("rst_data", xfer_data, 0);
        check("rst_sent", sent_count, 0);
        check("rst_err", timeout_err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        rst_tx = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);

        // Single word, receiver acks 3 cycles after seeing req
        do_reset();
        in_data  = 8'hA5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_req_early", xfer_req, 0);
        step();
        check("t1_req", xfer_req, 1);
        check("t1_data", xfer_data, 8'hA5);
        repeat (3) step();
        man_ack = 1'b1;
        wait_req(1'b0, n);
        check("t1_req_fall_edges", n, SYNC + 1);
        check("t1_sent_mid", sent_count, 0);
        check("t1_data_hold", xfer_data, 8'hA5);
        man_ack = 1'b0;
        wait_sent(1, n);
        check("t1_done_edges", n, SYNC + 1);
        check("t1_busy_end", busy, 0);

        // Burst into a stalled receiver
        do_reset();
        acc = 0;
        n   = 0;
        in_valid = 1'b1;
        while (acc < 5 && n < 20) begin
            in_data = BW'(acc + 1);
            if (in_ready) acc++;
            step();
            n++;
        end
        in_data = 8'h06;
        check("t2_accept_cycles", n, 5);
        check("t2_full", in_ready, 0);
        check("t2_head_launched", xfer_data, 8'h01);
        repeat (4) step();
        check("t2_still_full", in_ready, 0);
        rx_auto = 1'b1;
        n = 0;
        while (!(rx_words.size() == 6 && !busy && !in_valid) && n < 3000) begin
            if (in_valid && in_ready) begin
                step();
                in_valid = 1'b0;
            end else begin
                step();
            end
            n++;
        end
        check("t2_in_time", 32'(n < 3000), 1);
        check("t2_words", rx_words.size(), 6);
        for (int i = 0; i < rx_words.size() && i < 6; i++)
            check("t2_order", rx_words[i], i + 1);
        check("t2_sent", sent_count, 6);

        // Stale ack held through reset release
        man_ack = 1'b1;
        do_reset();
        repeat (3) step();
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_no_req", xfer_req, 0);
        end
        man_ack = 1'b0;
        wait_req(1'b1, n);
        check("t3_launch_edges", n, SYNC + 1);
        check("t3_data", xfer_data, 8'h3C);
        rx_auto = 1'b1;
        n = 0;
        while (sent_count != 1 && n < 200) begin
            step();
            n++;
        end
        check("t3_sent", sent_count, 1);

        // Timeout with a silent receiver, then a late ack
        do_reset();
        in_data  = 8'h5A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("t4_req", xfer_req, 1);
        n = 0;
        while (!timeout_err && n < 60) begin
            step();
            n++;
        end
        check("t4_timeout_cycles", n, TMO);
        check("t4_req_held", xfer_req, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        step();
        check("t4_err_resets", timeout_err, 1);
        man_ack = 1'b1;
        wait_req(1'b0, n);
        check("t4_late_ack", n, SYNC + 1);
        man_ack = 1'b0;
        wait_sent(1, n);
        check("t4_sent", sent_count, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t4_err_cleared", timeout_err, 0);

        // Reset in REQ_LO with two words buffered
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = BW'(8'h11 * (i + 1));
            step();
        end
        in_valid = 1'b0;
        check("t5_busy", busy, 1);
        man_ack = 1'b1;
        wait_req(1'b0, n);
        check("t5_in_req_lo", n, SYNC + 1);
        rst_tx = 1'b1;
        #1;
        check("t5_rst_req", xfer_req, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_sent", sent_count, 0);
        check("t5_rst_ready", in_ready, 0);
        man_ack = 1'b0;
        step();
        step();
        rst_tx = 1'b0;
        step();
        check("t5_ready", in_ready, 1);
        rx_words.delete();
        rx_auto = 1'b1;
        repeat (40) step();
        check("t5_nothing_sent", rx_words.size(), 0);
        check("t5_req_idle", xfer_req, 0);
        check("t5_sent_zero", sent_count, 0);

        // Randomized traffic; 17 transfers wrap the 4-bit counter to 1
        do_reset();
        run_random(17);
        run_random(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
